logic_gate_pipe: RTL

//  Parametrised, pipelined N-input bitwise gate with runtime-selectable function (AND/OR/XOR/NAND/NOR/XNOR).

---
 rtl/logic_gate_pipe_if.sv | 26 ++
 rtl/logic_gate_pipe.sv | 127 ++++++++++++
 2 files changed

// File: rtl/logic_gate_pipe_if.sv
// Streaming bus for logic_gate_pipe: operand beat in, result beat out.
interface logic_gate_pipe_if #(
   parameter int WIDTH = 8,
   parameter int N_IN  = 2
);
   logic                    in_valid;
   logic                    in_ready;
   logic [N_IN*WIDTH-1:0]   in_data;
   logic [2:0]              in_mode;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_err;

   // producer/consumer side (drives operands, accepts results)
   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   // gate pipeline side
   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/logic_gate_pipe.sv
// Pipelined N-input bitwise gate with per-beat selectable function and an
// elastic valid/ready pipeline of STAGES registers.

// One bit column: reduces bit b of every operand lane under the selected mode.
module logic_gate_pipe_col #(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0] bits,
   input  logic [2:0]      mode,
   output logic            y
);
   logic and_r, or_r, xor_r;

   assign and_r = &bits;
   assign or_r  = |bits;
   assign xor_r = ^bits;

   // mode decode; illegal codes produce 0 (flagged separately by the top)
   always_comb begin
      y = 1'b0;
      case (mode)
         3'd0:    y = and_r;
         3'd1:    y = or_r;
         3'd2:    y = xor_r;
         3'd3:    y = ~and_r;
         3'd4:    y = ~or_r;
         3'd5:    y = ~xor_r;
         default: y = 1'b0;
      endcase
   end
endmodule

module logic_gate_pipe #(
   parameter int WIDTH  = 8,
   parameter int N_IN   = 2,
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   logic_gate_pipe_if.slave  bus
);
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } beat_t;

   // transposed operands: cols[b][k] is bit b of lane k
   logic [WIDTH-1:0][N_IN-1:0] cols;
   logic [WIDTH-1:0]           f_data;
   logic                       f_err;
   beat_t                      f_beat;

   // stage state, index 1 is the stage nearest the input
   logic  [STAGES:1]           vld_q;
   beat_t [STAGES:1]           beat_q;
   // what each stage would load from its upstream neighbour
   logic  [STAGES:1]           src_vld;
   beat_t [STAGES:1]           src_beat;
   // stage i can take a new beat this cycle
   logic  [STAGES:1]           acc;

   genvar b, k, s;

   generate
      for (b = 0; b < WIDTH; b++) begin : g_col
         for (k = 0; k < N_IN; k++) begin : g_lane
            assign cols[b][k] = bus.in_data[k*WIDTH + b];
         end
         logic_gate_pipe_col #(.N_IN(N_IN)) u_col (
            .bits (cols[b]),
            .mode (bus.in_mode),
            .y    (f_data[b])
         );
      end
   endgenerate

   // modes 6 and 7 are illegal: result forced to 0 with the error flag set
   assign f_err       = bus.in_mode[2] & bus.in_mode[1];
   assign f_beat.data = f_err ? '0 : f_data;
   assign f_beat.err  = f_err;

   generate
      for (s = 1; s <= STAGES; s++) begin : g_src
         if (s == 1) begin : g_head
            assign src_vld[s]  = bus.in_valid;
            assign src_beat[s] = f_beat;
         end else begin : g_body
            assign src_vld[s]  = vld_q[s-1];
            assign src_beat[s] = beat_q[s-1];
         end
      end
   endgenerate

   // Stage i accepts if it or any later stage is empty, or the consumer is
   // taking the head beat. Written as a suffix scan over vld_q so the ready
   // chain never references itself.
   always_comb begin
      logic run_full;
      acc      = '0;
      run_full = 1'b1;
      for (int i = STAGES; i >= 1; i--) begin
         run_full = run_full & vld_q[i];
         acc[i]   = bus.out_ready | ~run_full;
      end
   end

   // Elastic advance: a stage that accepts takes its neighbour's valid bit,
   // and its payload only when a real beat arrives, so held data stays put.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         beat_q <= '0;
      end else begin
         for (int i = 1; i <= STAGES; i++) begin
            if (acc[i]) begin
               vld_q[i] <= src_vld[i];
               if (src_vld[i]) beat_q[i] <= src_beat[i];
            end
         end
      end
   end

   assign bus.in_ready  = acc[1];
   assign bus.out_valid = vld_q[STAGES];
   assign bus.out_data  = beat_q[STAGES].data;
   assign bus.out_err   = beat_q[STAGES].err;
endmodule
